gmii_to_pkt_134b: RTL and testbench

Receive-side packer that turns a GMII byte stream into the 134b packet word format consumed by the 134b-to-GMII transmit stage and the packet FIFOs.
- Strips the 0x55 preamble and the 0xD5 SFD.
- Packs frame bytes (FCS included, not checked) into 16-byte words with head/tail/valid tags.
- Sits between the MAC/PHY RX GMII interface and the packet-processing FIFO. There is no backpressure.

---
 rtl/gmii_to_pkt_134b.sv | 179 +++++++++++++++++
 tb/tb_gmii_to_pkt_134b.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_to_pkt_134b.sv
// GMII receive packer: strips preamble/SFD and packs frame bytes (FCS
// included) into 134-bit packet words {tag[1:0], vld[3:0], data[127:0]}.
// A full 16-byte word is held in a pending register until either the next
// data byte arrives (middle/head word) or the frame ends (tail word), so
// that the tail tag can be applied to the last word without lookahead.
module gmii_to_pkt_134b #(
    parameter int MAX_BYTES = 2047
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   gmii_data,
    input  logic         gmii_data_valid,
    output logic         pkt_data_valid,
    output logic [133:0] pkt_data,
    output logic [31:0]  cnt_pkt,
    output logic [31:0]  cnt_err_pkt
);

    localparam int K_W = $clog2(MAX_BYTES + 1);
    localparam logic [K_W-1:0] MAX_K = K_W'(MAX_BYTES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } state_t;

    state_t         state, state_next;
    logic [127:0]   asm_word, asm_word_next;
    logic [127:0]   pend_word, pend_word_next;
    logic           pend_full, pend_full_next;
    logic           first_word, first_word_next;
    logic           overflow, overflow_next;
    logic [K_W-1:0] byte_cnt, byte_cnt_next;
    logic           pkt_data_valid_next;
    logic [133:0]   pkt_data_next;
    logic [31:0]    cnt_pkt_next, cnt_err_pkt_next;
    logic [127:0]   asm_with_byte;

    // Current word with the incoming byte dropped into its lane (byte 0 in the MSBs)
    assign asm_with_byte = asm_word | ({gmii_data, 120'd0} >> {byte_cnt[3:0], 3'b000});

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath, output and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_word       <= '0;
            pend_word      <= '0;
            pend_full      <= 1'b0;
            first_word     <= 1'b0;
            overflow       <= 1'b0;
            byte_cnt       <= '0;
            pkt_data_valid <= 1'b0;
            pkt_data       <= '0;
            cnt_pkt        <= '0;
            cnt_err_pkt    <= '0;
        end else begin
            asm_word       <= asm_word_next;
            pend_word      <= pend_word_next;
            pend_full      <= pend_full_next;
            first_word     <= first_word_next;
            overflow       <= overflow_next;
            byte_cnt       <= byte_cnt_next;
            pkt_data_valid <= pkt_data_valid_next;
            pkt_data       <= pkt_data_next;
            cnt_pkt        <= cnt_pkt_next;
            cnt_err_pkt    <= cnt_err_pkt_next;
        end
    end

    // Next-state, packing and emission decisions
    always_comb begin
        state_next          = state;
        asm_word_next       = asm_word;
        pend_word_next      = pend_word;
        pend_full_next      = pend_full;
        first_word_next     = first_word;
        overflow_next       = overflow;
        byte_cnt_next       = byte_cnt;
        pkt_data_valid_next = 1'b0;
        pkt_data_next       = pkt_data;
        cnt_pkt_next        = cnt_pkt;
        cnt_err_pkt_next    = cnt_err_pkt;

        case (state)
            IDLE: begin
                if (gmii_data_valid) begin
                    if (gmii_data == 8'h55) begin
                        state_next = PREAMBLE;
                    end else begin
                        state_next       = DROP;
                        cnt_err_pkt_next = cnt_err_pkt + 32'd1;
                    end
                end
            end

            PREAMBLE: begin
                if (!gmii_data_valid) begin
                    state_next       = IDLE;
                    cnt_err_pkt_next = cnt_err_pkt + 32'd1;
                end else if (gmii_data == 8'hD5) begin
                    state_next      = DATA;
                    byte_cnt_next   = '0;
                    first_word_next = 1'b1;
                    pend_full_next  = 1'b0;
                    asm_word_next   = '0;
                    overflow_next   = 1'b0;
                end else if (gmii_data != 8'h55) begin
                    state_next       = DROP;
                    cnt_err_pkt_next = cnt_err_pkt + 32'd1;
                end
            end

            DATA: begin
                if (gmii_data_valid) begin
                    if (byte_cnt < MAX_K) begin
                        // A further byte proves the pending word is not the tail
                        if (pend_full) begin
                            pkt_data_valid_next = 1'b1;
                            pkt_data_next       = {1'b0, first_word, 4'hF, pend_word};
                            first_word_next     = 1'b0;
                            pend_full_next      = 1'b0;
                        end
                        if (byte_cnt[3:0] == 4'hF) begin
                            pend_word_next = asm_with_byte;
                            pend_full_next = 1'b1;
                            asm_word_next  = '0;
                        end else begin
                            asm_word_next = asm_with_byte;
                        end
                        byte_cnt_next = byte_cnt + K_W'(1);
                    end else begin
                        overflow_next = 1'b1;
                    end
                end else begin
                    state_next = IDLE;
                    if (byte_cnt[3:0] != 4'h0) begin
                        pkt_data_valid_next = 1'b1;
                        pkt_data_next       = {1'b1, first_word, 4'(byte_cnt[3:0] - 4'd1), asm_word};
                    end else if (pend_full) begin
                        pkt_data_valid_next = 1'b1;
                        pkt_data_next       = {1'b1, first_word, 4'hF, pend_word};
                    end
                    if ((byte_cnt[3:0] != 4'h0) || pend_full) begin
                        cnt_pkt_next = cnt_pkt + 32'd1;
                        if (overflow) begin
                            cnt_err_pkt_next = cnt_err_pkt + 32'd1;
                        end
                    end else begin
                        cnt_err_pkt_next = cnt_err_pkt + 32'd1;
                    end
                    asm_word_next   = '0;
                    pend_full_next  = 1'b0;
                    first_word_next = 1'b0;
                    overflow_next   = 1'b0;
                    byte_cnt_next   = '0;
                end
            end

            DROP: begin
                if (!gmii_data_valid) begin
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gmii_to_pkt_134b.sv
// Scoreboard bench for gmii_to_pkt_134b: stimulus pushes expected words
// (with the cycle they must appear on) and per-DUT monitors pop and compare.
module tb_gmii_to_pkt_134b;

    localparam logic [127:0] W0 = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] W1 = 128'h101112131415161718191A1B1C1D1E1F;
    localparam logic [127:0] W2 = 128'h202122232425262728292A2B2C2D2E2F;
    localparam logic [127:0] W3 = 128'h303132333435363738393A3B3C3D3E3F;

    typedef struct packed {
        logic [133:0] data;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   d0, d1;
    logic         v0, v1;
    logic         o_v0, o_v1;
    logic [133:0] o_d0, o_d1;
    logic [31:0]  cp0, ce0, cp1, ce1;

    exp_t         q0[$];
    exp_t         q1[$];
    logic [7:0]   stim[$];
    int           cyc = 0;
    int           total = 0;
    int           bad = 0;
    int           c;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    gmii_to_pkt_134b dut (
        .clk(clk), .rst_n(rst_n), .gmii_data(d0), .gmii_data_valid(v0),
        .pkt_data_valid(o_v0), .pkt_data(o_d0), .cnt_pkt(cp0), .cnt_err_pkt(ce0)
    );

    gmii_to_pkt_134b #(.MAX_BYTES(32)) dut_s (
        .clk(clk), .rst_n(rst_n), .gmii_data(d1), .gmii_data_valid(v1),
        .pkt_data_valid(o_v1), .pkt_data(o_d1), .cnt_pkt(cp1), .cnt_err_pkt(ce1)
    );

    task automatic check(input string name, input logic [133:0] act, input logic [133:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Monitor for the default-size instance
    always @(negedge clk) begin
        exp_t e;
        if (o_v0 === 1'b1) begin
            if (q0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL strobe0: unexpected word %h at cycle %0d, required none", o_d0, cyc);
            end else begin
                e = q0.pop_front();
                check("word0", o_d0, e.data);
                check("cycle0", 134'(cyc), 134'(e.cyc));
            end
        end
    end

    // Monitor for the MAX_BYTES=32 instance
    always @(negedge clk) begin
        exp_t e;
        if (o_v1 === 1'b1) begin
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL strobe1: unexpected word %h at cycle %0d, required none", o_d1, cyc);
            end else begin
                e = q1.pop_front();
                check("word1", o_d1, e.data);
                check("cycle1", 134'(cyc), 134'(e.cyc));
            end
        end
    end

    function automatic void build(input int npre, input bit sfd, input int n, input logic [7:0] first);
        stim.delete();
        repeat (npre) stim.push_back(8'h55);
        if (sfd) stim.push_back(8'hD5);
        for (int i = 0; i < n; i++) stim.push_back(8'(first + i));
    endfunction

    task automatic push0(input logic [133:0] d, input int at);
        exp_t e;
        e.data = d;
        e.cyc  = at;
        q0.push_back(e);
    endtask

    task automatic push1(input logic [133:0] d, input int at);
        exp_t e;
        e.data = d;
        e.cyc  = at;
        q1.push_back(e);
    endtask

    // Entered just after a negedge; element j is driven during cycle (entry cycle + j),
    // then one dv-low cycle follows. Optional reset pulse while element rst_at is driven.
    task automatic send(input bit sel, input int rst_at);
        for (int j = 0; j < stim.size(); j++) begin
            if (sel) begin d1 = stim[j]; v1 = 1'b1; end
            else     begin d0 = stim[j]; v0 = 1'b1; end
            if (rst_at >= 0 && j == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_valid", 134'(o_v0), 134'(0));
                check("rst_data", o_d0, 134'(0));
                check("rst_cnt_pkt", 134'(cp0), 134'(0));
                check("rst_cnt_err", 134'(ce0), 134'(0));
            end
            if (rst_at >= 0 && j == rst_at + 1) rst_n = 1'b1;
            @(negedge clk);
        end
        if (sel) begin d1 = 8'h00; v1 = 1'b0; end
        else     begin d0 = 8'h00; v0 = 1'b0; end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        d0 = 8'h00; v0 = 1'b0;
        d1 = 8'h00; v1 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid", 134'(o_v0), 134'(0));
        check("reset_data", o_d0, 134'(0));
        check("reset_cnt_pkt", 134'(cp0), 134'(0));
        check("reset_cnt_err", 134'(ce0), 134'(0));
        check("reset_s_data", o_d1, 134'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // 64-byte frame: head, two middles, full tail
        build(7, 1'b1, 64, 8'h00);
        c = cyc;
        push0({2'b01, 4'hF, W0}, c + 25);
        push0({2'b00, 4'hF, W1}, c + 41);
        push0({2'b00, 4'hF, W2}, c + 57);
        push0({2'b10, 4'hF, W3}, c + 73);
        send(1'b0, -1);
        repeat (3) @(negedge clk);
        check("f64_cnt_pkt", 134'(cp0), 134'(1));
        check("f64_cnt_err", 134'(ce0), 134'(0));

        // 60-byte frame: partial tail with zero padding
        build(7, 1'b1, 60, 8'h00);
        c = cyc;
        push0({2'b01, 4'hF, W0}, c + 25);
        push0({2'b00, 4'hF, W1}, c + 41);
        push0({2'b00, 4'hF, W2}, c + 57);
        push0({2'b10, 4'hB, 128'h303132333435363738393A3B00000000}, c + 69);
        send(1'b0, -1);
        repeat (3) @(negedge clk);
        check("f60_cnt_pkt", 134'(cp0), 134'(2));

        // 10-byte runt: single head+tail word
        build(7, 1'b1, 10, 8'hA0);
        c = cyc;
        push0({2'b11, 4'h9, 128'hA0A1A2A3A4A5A6A7A8A9000000000000}, c + 19);
        send(1'b0, -1);
        repeat (3) @(negedge clk);
        check("runt_cnt_pkt", 134'(cp0), 134'(3));

        // Exactly 16 bytes: one head+tail word on the dv-low edge only
        build(7, 1'b1, 16, 8'h00);
        c = cyc;
        push0({2'b11, 4'hF, W0}, c + 25);
        send(1'b0, -1);
        repeat (3) @(negedge clk);
        check("f16_cnt_pkt", 134'(cp0), 134'(4));

        // Bad preamble byte, rest of frame (including a D5) ignored
        build(2, 1'b0, 0, 8'h00);
        stim.push_back(8'h12);
        stim.push_back(8'hD5);
        stim.push_back(8'h01);
        stim.push_back(8'h02);
        send(1'b0, -1);
        repeat (2) @(negedge clk);
        check("badpre_cnt_err", 134'(ce0), 134'(1));

        // dv falls after a single 0x55
        build(1, 1'b0, 0, 8'h00);
        send(1'b0, -1);
        repeat (2) @(negedge clk);
        check("shortpre_cnt_err", 134'(ce0), 134'(2));

        // SFD followed immediately by dv low
        build(7, 1'b1, 0, 8'h00);
        send(1'b0, -1);
        repeat (2) @(negedge clk);
        check("empty_cnt_err", 134'(ce0), 134'(3));
        check("empty_cnt_pkt", 134'(cp0), 134'(4));

        // MAX_BYTES=32 instance with a 40-byte frame: bytes 32..39 discarded
        build(7, 1'b1, 40, 8'h00);
        c = cyc;
        push1({2'b01, 4'hF, W0}, c + 25);
        push1({2'b10, 4'hF, W1}, c + 49);
        send(1'b1, -1);
        repeat (3) @(negedge clk);
        check("ovf_cnt_pkt", 134'(cp1), 134'(1));
        check("ovf_cnt_err", 134'(ce1), 134'(1));

        // Reset asserted while byte 20 is on the wire: head word already out, nothing after
        build(7, 1'b1, 64, 8'h00);
        c = cyc;
        push0({2'b01, 4'hF, W0}, c + 25);
        send(1'b0, 28);
        repeat (3) @(negedge clk);
        check("rstmid_cnt_pkt", 134'(cp0), 134'(0));
        check("rstmid_cnt_err", 134'(ce0), 134'(1));

        // Back-to-back 64-byte frames with a single dv-low gap
        build(7, 1'b1, 64, 8'h00);
        c = cyc;
        for (int f = 0; f < 2; f++) begin
            push0({2'b01, 4'hF, W0}, c + 73 * f + 25);
            push0({2'b00, 4'hF, W1}, c + 73 * f + 41);
            push0({2'b00, 4'hF, W2}, c + 73 * f + 57);
            push0({2'b10, 4'hF, W3}, c + 73 * f + 73);
        end
        send(1'b0, -1);
        send(1'b0, -1);
        repeat (3) @(negedge clk);
        check("b2b_cnt_pkt", 134'(cp0), 134'(2));
        check("b2b_cnt_err", 134'(ce0), 134'(1));

        check("q0_drained", 134'(q0.size()), 134'(0));
        check("q1_drained", 134'(q1.size()), 134'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
